capture_sequencer: RTL and testbench
====================================

// Module: capture_sequencer
// PURPOSE
//  Sequences one capture/readout cycle of the single-port 10-bit sample RAM.
//  On start it writes cap_len+1 consecutive valid samples to addresses 0..cap_len,
//  then reads them back in address order and streams them out on a valid/ready port
//  (e.g. to the UART/host path). It owns every RAM port; no other block drives the RAM.
// PARAMETERS
//  ADDR_W  16  RAM address width; maximum capture depth is 2**ADDR_W samples
//  DATA_W  10  sample / RAM data width
//  RD_LAT  2   RAM read latency in clocks, from address presented to ram_rdata valid (>=1)
// PORTS
//  clk          in   1       system clock; all logic is on its rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  start        in   1       1-cycle request to begin a capture; honoured only in IDLE
//  abort        in   1       cancels the current operation and returns to IDLE
//  cap_len      in   ADDR_W  sample count minus 1; latched on an accepted start
//  sample_valid in   1       sample_in is a valid sample this cycle
//  sample_in    in   DATA_W  sample data
//  ram_addr     out  ADDR_W  RAM address
//  ram_wdata    out  DATA_W  RAM write data (= sample_in)
//  ram_wren     out  1       RAM write enable
//  ram_rdata    in   DATA_W  RAM read data
//  out_data     out  DATA_W  readout sample (registered)
//  out_valid    out  1       out_data is valid; held until out_ready
//  out_ready    in   1       downstream accepts out_data when out_valid is high
//  busy         out  1       high in every state except IDLE
//  done         out  1       1-cycle pulse after the last sample is accepted
// BEHAVIOUR
//  Reset: state=IDLE; wr_ptr=rd_ptr=len_q=0; out_data=0; out_valid=0; done=0; busy=0;
//   ram_wren=0; ram_addr=0.
//  States: IDLE, CAPTURE, RD_REQ, RD_WAIT, OUT, DONE (registered FSM).
//  IDLE: if start, then len_q<=cap_len, wr_ptr<=0, rd_ptr<=0, go to CAPTURE (busy high next cycle).
//  CAPTURE: ram_wren = sample_valid & ~abort (combinational); ram_addr=wr_ptr;
//   each write increments wr_ptr. The write at wr_ptr==len_q is the last one:
//   go to RD_REQ and set wr_ptr<=0. Cycles without sample_valid just wait, with no timeout.
//  RD_REQ: ram_addr=rd_ptr for exactly 1 cycle, then RD_WAIT with wait counter=RD_LAT-1.
//  RD_WAIT: ram_addr stays at rd_ptr. When the counter reaches 0, register
//   out_data<=ram_rdata, set out_valid<=1, and go to OUT.
//  OUT: out_valid and out_data stay stable while out_ready is low.
//   On out_valid&out_ready: clear out_valid. If rd_ptr==len_q go to DONE, else
//   increment rd_ptr and go to RD_REQ.
//   Throughput is one word per RD_LAT+2 cycles at most (out_ready tied high).
//  DONE: done=1 for 1 cycle, busy still 1; then IDLE.
//  ram_addr = wr_ptr in CAPTURE, rd_ptr in RD_REQ/RD_WAIT/OUT, else 0. ram_wren is 0
//   outside CAPTURE.
//  Boundaries: cap_len=0 gives 1 sample; cap_len=2**ADDR_W-1 fills the whole RAM
//   (pointers are ADDR_W wide; the compare against len_q ends the phase, with no wrap).
//  Ignored inputs: start when not in IDLE (len_q unchanged); sample_valid outside
//   CAPTURE (not written); changes to cap_len outside an accepted start.
//  abort (any non-IDLE state, including the same cycle as a last write or handshake):
//   next state IDLE, out_valid<=0, pointers<=0, no done pulse. The abort cycle never writes.
//   abort in IDLE has no effect. If start and abort are both high in IDLE, start wins.
//  rst_n asserted mid-operation returns everything to the reset values asynchronously.
//   RAM contents are not cleared.
// TESTING
//  1 cap_len=3, RD_LAT=2, samples 5,6,7,8 (1 per cycle), out_ready=1
//    -> writes at addr 0..3, out stream 5,6,7,8, done pulses once, busy then falls.
//  2 Same as 1 with sample_valid gaps and out_ready low for 3 cycles on word 2
//    -> no extra writes, out_data=6 held stable, same output order, 1 done.
//  3 cap_len=0, sample 0x3FF -> exactly 1 write and 1 output of 0x3FF, then done.
//  4 cap_len=16'hFFFF, ramp of 65536 samples -> last write at addr 0xFFFF, readout 0..0xFFFF
//    in order, no address wrap.
//  5 abort after 2 of 4 writes, then abort during OUT -> IDLE next cycle, out_valid=0,
//    no done; a following start with cap_len=1 runs a normal capture from address 0.
//  6 start pulsed during CAPTURE with a different cap_len, and rst_n pulsed low during
//    RD_WAIT -> first start ignored; after reset all outputs are 0 and state is IDLE.

Source files
------------

// File: rtl/capture_sequencer_if.sv
// capture_sequencer_if
//   Groups the two buses owned by the capture sequencer: the single-port
//   sample RAM port and the valid/ready readout stream.
//   master : the sequencer (drives RAM address/write side and the stream)
//   slave  : the RAM / downstream sink (returns read data and ready)
//   Signals:
//     ram_addr  [ADDR_W] RAM address
//     ram_wdata [DATA_W] RAM write data
//     ram_wren          RAM write enable
//     ram_rdata [DATA_W] RAM read data
//     out_data  [DATA_W] readout sample
//     out_valid         readout sample valid
//     out_ready         downstream accepts readout sample
interface capture_sequencer_if #(
  parameter int unsigned ADDR_W = 32'd16,
  parameter int unsigned DATA_W = 32'd10
);
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output ram_addr,
    output ram_wdata,
    output ram_wren,
    input  ram_rdata,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  ram_addr,
    input  ram_wdata,
    input  ram_wren,
    output ram_rdata,
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/capture_sequencer.sv
// capture_sequencer
//   Runs one capture/readout cycle of the single-port sample RAM: on start it
//   writes cap_len+1 valid samples to addresses 0..cap_len, then reads them
//   back in address order and streams them out on a valid/ready port.
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     start          1-cycle capture request (honoured only when idle)
//     abort          cancel current operation, return to idle
//     cap_len        sample count minus 1, latched on an accepted start
//     sample_valid   sample_in carries a sample this cycle
//     sample_in      sample data
//     bus            RAM port and readout stream (master side)
//     busy           high whenever not idle
//     done           1-cycle pulse after the last sample is accepted
module capture_sequencer #(
  parameter int unsigned ADDR_W = 32'd16,
  parameter int unsigned DATA_W = 32'd10,
  parameter int unsigned RD_LAT = 32'd2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ADDR_W-1:0]        cap_len,
  input  logic                     sample_valid,
  input  logic [DATA_W-1:0]        sample_in,
  capture_sequencer_if.master      bus,
  output logic                     busy,
  output logic                     done
);

  // Wait counter must hold RD_LAT-1; keep at least one bit for RD_LAT==1.
  localparam int unsigned CNT_W = (RD_LAT > 32'd1) ? $clog2(RD_LAT) : 32'd1;
  localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'(RD_LAT - 32'd1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_OUT     = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t            state_r,     state_s;
  logic [ADDR_W-1:0] wr_ptr_r,    wr_ptr_s;
  logic [ADDR_W-1:0] rd_ptr_r,    rd_ptr_s;
  logic [ADDR_W-1:0] len_q_r,     len_q_s;
  logic [CNT_W-1:0]  wait_cnt_r,  wait_cnt_s;
  logic [DATA_W-1:0] out_data_r,  out_data_s;
  logic              out_valid_r, out_valid_s;
  logic              abort_s;

  // Abort is only meaningful outside IDLE, so start always wins when idle.
  assign abort_s = abort && (state_r != ST_IDLE);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      len_q_r     <= '0;
      wait_cnt_r  <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      wr_ptr_r    <= wr_ptr_s;
      rd_ptr_r    <= rd_ptr_s;
      len_q_r     <= len_q_s;
      wait_cnt_r  <= wait_cnt_s;
      out_data_r  <= out_data_s;
      out_valid_r <= out_valid_s;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_s     = state_r;
    wr_ptr_s    = wr_ptr_r;
    rd_ptr_s    = rd_ptr_r;
    len_q_s     = len_q_r;
    wait_cnt_s  = wait_cnt_r;
    out_data_s  = out_data_r;
    out_valid_s = out_valid_r;

    if (abort_s) begin
      state_s     = ST_IDLE;
      wr_ptr_s    = '0;
      rd_ptr_s    = '0;
      out_valid_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            len_q_s  = cap_len;
            wr_ptr_s = '0;
            rd_ptr_s = '0;
            state_s  = ST_CAPTURE;
          end else begin
            state_s  = ST_IDLE;
          end
        end
        ST_CAPTURE: begin
          if (sample_valid) begin
            // Compare against len_q instead of relying on wrap: a full-depth
            // capture ends exactly at the top address.
            if (wr_ptr_r == len_q_r) begin
              wr_ptr_s = '0;
              state_s  = ST_RD_REQ;
            end else begin
              wr_ptr_s = wr_ptr_r + PTR_ONE;
            end
          end else begin
            state_s = ST_CAPTURE;
          end
        end
        ST_RD_REQ: begin
          wait_cnt_s = WAIT_INIT;
          state_s    = ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (wait_cnt_r == '0) begin
            out_data_s  = bus.ram_rdata;
            out_valid_s = 1'b1;
            state_s     = ST_OUT;
          end else begin
            wait_cnt_s  = wait_cnt_r - CNT_ONE;
          end
        end
        ST_OUT: begin
          if (out_valid_r && bus.out_ready) begin
            out_valid_s = 1'b0;
            if (rd_ptr_r == len_q_r) begin
              state_s  = ST_DONE;
            end else begin
              rd_ptr_s = rd_ptr_r + PTR_ONE;
              state_s  = ST_RD_REQ;
            end
          end else begin
            state_s = ST_OUT;
          end
        end
        ST_DONE: begin
          state_s = ST_IDLE;
        end
        default: begin
          state_s     = ST_IDLE;
          out_valid_s = 1'b0;
        end
      endcase
    end
  end

  // RAM address mux: write pointer while capturing, read pointer during readout.
  always_comb begin
    case (state_r)
      ST_CAPTURE: bus.ram_addr = wr_ptr_r;
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_OUT:     bus.ram_addr = rd_ptr_r;
      default:    bus.ram_addr = '0;
    endcase
  end

  // The abort cycle never writes, even with a valid sample present.
  assign bus.ram_wren  = (state_r == ST_CAPTURE) && sample_valid && !abort;
  assign bus.ram_wdata = sample_in;
  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign busy          = (state_r != ST_IDLE);
  assign done          = (state_r == ST_DONE);

endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer
//   Directed bench for capture_sequencer with a behavioural RAM of latency
//   RD_LAT. ADDR_W is reduced so a full-depth capture fits the cycle budget.
module tb_capture_sequencer;
  localparam int unsigned ADDR_W = 32'd8;
  localparam int unsigned DATA_W = 32'd10;
  localparam int unsigned RD_LAT = 32'd2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] cap_len;
  logic              sample_valid;
  logic [DATA_W-1:0] sample_in;
  logic              busy;
  logic              done;

  capture_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  capture_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .cap_len      (cap_len),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .bus          (bus),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with RD_LAT read pipeline.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];

  always @(posedge clk) begin
    if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_wdata;
    rd_pipe[0] <= mem[bus.ram_addr];
    for (int i = 1; i < int'(RD_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.ram_rdata = rd_pipe[RD_LAT-1];

  // Monitor: logs writes, accepted output words and done pulses.
  int wr_addr_q[$];
  int wr_data_q[$];
  int out_q[$];
  int done_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ram_wren) begin
        wr_addr_q.push_back(int'(bus.ram_addr));
        wr_data_q.push_back(int'(bus.ram_wdata));
      end
      if (bus.out_valid && bus.out_ready) out_q.push_back(int'(bus.out_data));
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  int checks_cnt = 0;
  int errors_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] len);
    start   = 1'b1;
    cap_len = len;
    tick();
    start   = 1'b0;
  endtask

  task automatic feed(input logic [DATA_W-1:0] v, input int gap);
    sample_valid = 1'b0;
    repeat (gap) tick();
    sample_valid = 1'b1;
    sample_in    = v;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget, output int n);
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check_val(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!bus.out_valid && n < budget) begin
      tick();
      n++;
    end
    check_val(tag, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic check_run(input string tag, input int wr0, input int out0, input int done0,
                           input int exp_vals[$]);
    check_val({tag, "_nwr"}, 32'(wr_addr_q.size() - wr0), 32'(exp_vals.size()));
    check_val({tag, "_nout"}, 32'(out_q.size() - out0), 32'(exp_vals.size()));
    foreach (exp_vals[k]) begin
      if (wr0 + k < wr_addr_q.size()) begin
        check_val({tag, "_waddr"}, 32'(wr_addr_q[wr0+k]), 32'(k));
        check_val({tag, "_wdata"}, 32'(wr_data_q[wr0+k]), 32'(exp_vals[k]));
      end
      if (out0 + k < out_q.size()) begin
        check_val({tag, "_out"}, 32'(out_q[out0+k]), 32'(exp_vals[k]));
      end
    end
    check_val({tag, "_done"}, 32'(done_cnt - done0), 32'd1);
  endtask

  int wr0, out0, done0, n;
  int exp_vals[$];

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    cap_len       = '0;
    sample_valid  = 1'b0;
    sample_in     = '0;
    bus.out_ready = 1'b0;
    #3;
    check_val("rst_busy",      32'(busy),          32'd0);
    check_val("rst_done",      32'(done),          32'd0);
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_out_data",  32'(bus.out_data),  32'd0);
    check_val("rst_wren",      32'(bus.ram_wren),  32'd0);
    check_val("rst_addr",      32'(bus.ram_addr),  32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Test 1: four samples back to back, out_ready tied high.
    wr0 = wr_addr_q.size(); out0 = out_q.size(); done0 = done_cnt;
    bus.out_ready = 1'b1;
    do_start(8'd3);
    check_val("t1_busy", 32'(busy), 32'd1);
    feed(10'd5, 0); feed(10'd6, 0); feed(10'd7, 0); feed(10'd8, 0);
    wait_idle("t1_idle", 200, n);
    check_val("t1_cycles", 32'(n), 32'd17);
    exp_vals = '{5, 6, 7, 8};
    check_run("t1", wr0, out0, done0, exp_vals);

    // Test 2: sample gaps and backpressure on the second word.
    wr0 = wr_addr_q.size(); out0 = out_q.size(); done0 = done_cnt;
    bus.out_ready = 1'b0;
    do_start(8'd3);
    feed(10'd5, 0); feed(10'd6, 2); feed(10'd7, 1); feed(10'd8, 3);
    for (int w = 0; w < 4; w++) begin
      wait_valid("t2_valid", 50);
      if (w == 1) begin
        repeat (3) begin
          check_val("t2_hold_data",  32'(bus.out_data),  32'd6);
          check_val("t2_hold_valid", 32'(bus.out_valid), 32'd1);
          tick();
        end
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
    wait_idle("t2_idle", 50, n);
    check_run("t2", wr0, out0, done0, exp_vals);

    // Test 3: single-sample capture.
    wr0 = wr_addr_q.size(); out0 = out_q.size(); done0 = done_cnt;
    bus.out_ready = 1'b1;
    do_start(8'd0);
    feed(10'h3FF, 1);
    wait_idle("t3_idle", 50, n);
    exp_vals = '{10'h3FF};
    check_run("t3", wr0, out0, done0, exp_vals);

    // Test 4: full-depth ramp, no address wrap.
    wr0 = wr_addr_q.size(); out0 = out_q.size(); done0 = done_cnt;
    exp_vals.delete();
    do_start(8'hFF);
    for (int i = 0; i < 256; i++) begin
      feed(10'(i), 0);
      exp_vals.push_back(i);
    end
    wait_idle("t4_idle", 1200, n);
    check_run("t4", wr0, out0, done0, exp_vals);
    check_val("t4_last_addr", 32'(wr_addr_q[wr_addr_q.size()-1]), 32'hFF);

    // Test 5a: abort after two writes; the abort cycle must not write.
    wr0 = wr_addr_q.size(); done0 = done_cnt;
    do_start(8'd3);
    feed(10'd30, 0); feed(10'd31, 0);
    sample_valid = 1'b1; sample_in = 10'd32; abort = 1'b1;
    #1;
    check_val("t5a_abort_wren", 32'(bus.ram_wren), 32'd0);
    tick();
    abort = 1'b0; sample_valid = 1'b0;
    check_val("t5a_busy",  32'(busy), 32'd0);
    check_val("t5a_nwr",   32'(wr_addr_q.size() - wr0), 32'd2);
    check_val("t5a_done",  32'(done_cnt - done0), 32'd0);

    // Test 5b: abort while a word is waiting in OUT.
    out0 = out_q.size(); done0 = done_cnt;
    bus.out_ready = 1'b0;
    do_start(8'd3);
    feed(10'd40, 0); feed(10'd41, 0); feed(10'd42, 0); feed(10'd43, 0);
    wait_valid("t5b_valid", 20);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("t5b_busy",      32'(busy),          32'd0);
    check_val("t5b_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("t5b_addr",      32'(bus.ram_addr),  32'd0);
    tick();
    check_val("t5b_done",      32'(done_cnt - done0), 32'd0);
    check_val("t5b_nout",      32'(out_q.size() - out0), 32'd0);

    // Test 5c: normal two-sample run after aborts.
    wr0 = wr_addr_q.size(); out0 = out_q.size(); done0 = done_cnt;
    bus.out_ready = 1'b1;
    do_start(8'd1);
    feed(10'd50, 0); feed(10'd51, 1);
    wait_idle("t5c_idle", 50, n);
    exp_vals = '{50, 51};
    check_run("t5c", wr0, out0, done0, exp_vals);

    // Test 6: start during CAPTURE ignored; async reset during RD_WAIT.
    wr0 = wr_addr_q.size();
    do_start(8'd3);
    feed(10'd60, 0);
    start = 1'b1; cap_len = 8'd1;
    tick();
    start = 1'b0;
    feed(10'd61, 0); feed(10'd62, 0); feed(10'd63, 0);
    tick();
    check_val("t6_nwr",       32'(wr_addr_q.size() - wr0), 32'd4);
    check_val("t6_wait_busy", 32'(busy),          32'd1);
    check_val("t6_wait_vld",  32'(bus.out_valid), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_busy",      32'(busy),          32'd0);
    check_val("t6_rst_done",      32'(done),          32'd0);
    check_val("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("t6_rst_out_data",  32'(bus.out_data),  32'd0);
    check_val("t6_rst_addr",      32'(bus.ram_addr),  32'd0);
    check_val("t6_rst_wren",      32'(bus.ram_wren),  32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check_val("t6_post_busy",  32'(busy),          32'd0);
    check_val("t6_post_valid", 32'(bus.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end
endmodule
